// File: rtl/bpred_update_sched.sv
// bpred_update_sched: single point of control for all writes into the gshare
// predictor. It walks the BTB/PHT with clear strobes after reset or on a flush
// request. It turns resolved branches into one-cycle fetch redirects. It also
// queues training updates for the predictor's single stallable update port.
// Optional build macro: BPRED_STATS_EN adds saturating branch/mispredict
// counters on statBranches/statMispred. Without it those ports are tied to 0.
module bpred_update_sched #(
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_ENTRIES = 128,
  parameter int QDEPTH      = 4,
  parameter int CLR_ENTRIES = (BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES,
  parameter int CLR_W       = $clog2(CLR_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resValid,
  output logic             resReady,
  input  logic [31:0]      resPc,
  input  logic             resTaken,
  input  logic [31:0]      resTarget,
  input  logic             resPredTaken,
  input  logic [31:0]      resPredTarget,
  output logic             redirectValid,
  output logic [31:0]      redirectPc,
  output logic             updValid,
  input  logic             updReady,
  output logic [31:0]      updPc,
  output logic             updTaken,
  output logic [31:0]      updTarget,
  output logic             clrValid,
  output logic [CLR_W-1:0] clrIndex,
  output logic             predEnable,
  input  logic             flushReq,
  output logic             busy,
  output logic [31:0]      statBranches,
  output logic [31:0]      statMispred
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [CLR_W-1:0] clr_index;
  logic             pred_enable;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  // Update FIFO: storage is never reset, only the pointers and occupancy.
  logic [31:0]      q_pc     [QDEPTH];
  logic             q_taken  [QDEPTH];
  logic [31:0]      q_target [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic        full;
  logic        empty;
  logic        accept;
  logic        pop;
  logic        mispredict;
  logic [31:0] redirect_target;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A full FIFO refuses a resolution even if the head pops in the same cycle.
  assign resReady = (state == RUN) && !full;
  assign updValid = (state != CLEAR) && !empty;
  assign accept   = resValid && resReady;
  assign pop      = updValid && updReady;

  assign mispredict      = (resTaken != resPredTaken) ||
                           (resTaken && (resPredTarget != resTarget));
  assign redirect_target = resTaken ? resTarget : (resPc + 32'd4);

  assign updPc     = q_pc[rd_ptr];
  assign updTaken  = q_taken[rd_ptr];
  assign updTarget = q_target[rd_ptr];

  assign clrValid      = (state == CLEAR);
  assign clrIndex      = clr_index;
  assign busy          = (state != RUN);
  assign predEnable    = pred_enable;
  assign redirectValid = redirect_valid;
  assign redirectPc    = redirect_pc;

  // Occupancy after this cycle's enqueue/dequeue; simultaneous push and pop cancel.
  always_comb begin
    count_next = count;
    if (accept && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!accept && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset discards any queued updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // FIFO storage write for each accepted resolution.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_pc[wr_ptr]     <= resPc;
      q_taken[wr_ptr]  <= resTaken;
      q_target[wr_ptr] <= resTarget;
    end
  end

  // Control FSM: clear walk, normal run, drain before re-clear; redirect is registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= CLEAR;
      clr_index      <= '0;
      pred_enable    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && mispredict;
      if (accept) redirect_pc <= redirect_target;
      case (state)
        CLEAR: begin
          if (flushReq) begin
            clr_index <= '0;
          end else if (clr_index == CLR_LAST) begin
            state       <= RUN;
            clr_index   <= '0;
            pred_enable <= 1'b1;
          end else begin
            clr_index <= clr_index + CLR_W'(1);
          end
        end
        RUN: begin
          if (flushReq) begin
            state <= DRAIN;
            // Entering DRAIN with nothing queued: that single cycle already runs disabled.
            if (count_next == '0) pred_enable <= 1'b0;
          end
        end
        DRAIN: begin
          if (empty) begin
            state       <= CLEAR;
            clr_index   <= '0;
            pred_enable <= 1'b0;
          end else if (count_next == '0) begin
            pred_enable <= 1'b0;
          end
        end
        default: begin
          state       <= CLEAR;
          clr_index   <= '0;
          pred_enable <= 1'b0;
        end
      endcase
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  // Saturating counters of accepted and mispredicted resolutions; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (accept && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (accept && mispredict && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

  assign statBranches = stat_branches;
  assign statMispred  = stat_mispred;
`else
  assign statBranches = '0;
  assign statMispred  = '0;
`endif

endmodule

// File: tb/tb_bpred_update_sched.sv
// Testbench for bpred_update_sched: directed scenarios followed by random
// traffic. All traffic is checked every cycle against a queue-based
// behavioural model of the scheduler.
module tb_bpred_update_sched;

  localparam int QD  = 4;
  localparam int CLR = 128;
  localparam int CW  = $clog2(CLR);

  localparam int M_WALK  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          resValid = 1'b0;
  logic          resReady;
  logic [31:0]   resPc = '0;
  logic          resTaken = 1'b0;
  logic [31:0]   resTarget = '0;
  logic          resPredTaken = 1'b0;
  logic [31:0]   resPredTarget = '0;
  logic          redirectValid;
  logic [31:0]   redirectPc;
  logic          updValid;
  logic          updReady = 1'b0;
  logic [31:0]   updPc;
  logic          updTaken;
  logic [31:0]   updTarget;
  logic          clrValid;
  logic [CW-1:0] clrIndex;
  logic          predEnable;
  logic          flushReq = 1'b0;
  logic          busy;
  logic [31:0]   statBranches;
  logic [31:0]   statMispred;

  always #5 clk = ~clk;

  bpred_update_sched #(.BTB_ENTRIES(32), .PHT_ENTRIES(128), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .resValid(resValid), .resReady(resReady), .resPc(resPc), .resTaken(resTaken),
    .resTarget(resTarget), .resPredTaken(resPredTaken), .resPredTarget(resPredTarget),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .updValid(updValid), .updReady(updReady), .updPc(updPc), .updTaken(updTaken),
    .updTarget(updTarget), .clrValid(clrValid), .clrIndex(clrIndex),
    .predEnable(predEnable), .flushReq(flushReq), .busy(busy),
    .statBranches(statBranches), .statMispred(statMispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  upd_t        mq[$];
  int          m_mode = M_WALK;
  int          m_idx  = 0;
  bit          m_pe   = 1'b0;
  bit          m_rv   = 1'b0;
  logic [31:0] m_rpc  = '0;
  int          m_br   = 0;
  int          m_mp   = 0;
  int          pops_seen;
  int          walk_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the current cycle.
  task automatic check_outputs();
    chk("resReady", 32'(resReady), 32'(m_mode == M_RUN && mq.size() < QD));
    chk("updValid", 32'(updValid), 32'(m_mode != M_WALK && mq.size() > 0));
    if (m_mode != M_WALK && mq.size() > 0) begin
      chk("updPc", updPc, mq[0].pc);
      chk("updTaken", 32'(updTaken), 32'(mq[0].taken));
      chk("updTarget", updTarget, mq[0].target);
    end
    chk("clrValid", 32'(clrValid), 32'(m_mode == M_WALK));
    chk("clrIndex", 32'(clrIndex), 32'(m_idx));
    chk("clr_upd_excl", 32'(clrValid && updValid), 32'd0);
    chk("predEnable", 32'(predEnable), 32'(m_pe));
    chk("busy", 32'(busy), 32'(m_mode != M_RUN));
    chk("redirectValid", 32'(redirectValid), 32'(m_rv));
    if (m_rv) chk("redirectPc", redirectPc, m_rpc);
`ifdef BPRED_STATS_EN
    chk("statBranches", statBranches, 32'(m_br));
    chk("statMispred", statMispred, 32'(m_mp));
`else
    chk("statBranches", statBranches, 32'd0);
    chk("statMispred", statMispred, 32'd0);
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   acc;
    bit   mis;
    upd_t e;
    if (!rst) begin
      m_mode = M_WALK; m_idx = 0; mq.delete(); m_pe = 0; m_rv = 0; m_rpc = '0;
      m_br = 0; m_mp = 0;
      return;
    end
    m_rv = 0;
    if (m_mode == M_WALK) begin
      if (flushReq) m_idx = 0;
      else if (m_idx == CLR - 1) begin m_mode = M_RUN; m_idx = 0; m_pe = 1; end
      else m_idx++;
    end else if (m_mode == M_RUN) begin
      acc = resValid && (mq.size() < QD);
      if (mq.size() > 0 && updReady) void'(mq.pop_front());
      if (acc) begin
        mis = (resTaken != resPredTaken) || (resTaken && resPredTarget != resTarget);
        e.pc = resPc; e.taken = resTaken; e.target = resTarget;
        mq.push_back(e);
        m_rv  = mis;
        m_rpc = resTaken ? resTarget : resPc + 32'd4;
        m_br++;
        if (mis) m_mp++;
      end
      if (flushReq) m_mode = M_DRAIN;
    end else begin
      if (mq.size() == 0) begin m_mode = M_WALK; m_idx = 0; end
      else if (updReady) void'(mq.pop_front());
    end
    if (m_mode == M_DRAIN && mq.size() == 0) m_pe = 0;
  endtask

  task automatic tick();
    check_outputs();
    if (updValid && updReady) pops_seen++;
    if (clrValid) walk_cnt++;
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    resValid = 1'b1; resPc = pc; resTaken = tk; resTarget = tgt;
    resPredTaken = ptk; resPredTarget = ptgt;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    repeat (3) tick();
    chk("rst_redirectPc", redirectPc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Initial clear walk
    rst = 1'b1;
    walk_cnt = 0;
    repeat (CLR) tick();
    chk("walk_len", 32'(walk_cnt), 32'd128);
    chk("walk_done_pe", 32'(predEnable), 32'd1);
    chk("walk_done_ready", 32'(resReady), 32'd1);

    // Mispredict redirects
    updReady = 1'b1;
    send(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("redir_a_v", 32'(redirectValid), 32'd1);
    chk("redir_a_pc", redirectPc, 32'h200);
    send(32'h104, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("redir_b_v", 32'(redirectValid), 32'd1);
    chk("redir_b_pc", redirectPc, 32'h108);
    resValid = 1'b0;
    tick();
    chk("redir_idle", 32'(redirectValid), 32'd0);
    repeat (2) tick();

    // Correct prediction, update held until updReady
    updReady = 1'b0;
    send(32'h300, 1'b1, 32'h400, 1'b1, 32'h400);
    resValid = 1'b0;
    chk("nomis_v", 32'(redirectValid), 32'd0);
    chk("hold_pc", updPc, 32'h300);
    repeat (3) tick();
    chk("hold_pc2", updPc, 32'h300);
    updReady = 1'b1;
    tick();
    updReady = 1'b0;

    // Fill the FIFO: the fifth resolution is refused
    for (int i = 0; i < 4; i++) send(32'h1000 + 32'(i) * 4, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("full_ready", 32'(resReady), 32'd0);
    send(32'h1010, 1'b0, 32'h0, 1'b0, 32'h0);
    resValid = 1'b0;
    updReady = 1'b1;
    chk("full_head", updPc, 32'h1000);
    tick();
    chk("ready_after_pop", 32'(resReady), 32'd1);
    repeat (5) tick();

    // Flush with two entries queued
    updReady = 1'b0;
    send(32'h2000, 1'b1, 32'h2100, 1'b1, 32'h2100);
    send(32'h2004, 1'b1, 32'h2200, 1'b1, 32'h2200);
    resValid = 1'b0;
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    chk("drain_ready", 32'(resReady), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    updReady = 1'b1;
    pops_seen = 0;
    walk_cnt = 0;
    for (int i = 0; i < 300 && m_mode != M_RUN; i++) tick();
    chk("drain_pops", 32'(pops_seen), 32'd2);
    chk("flush_walk_len", 32'(walk_cnt), 32'd128);
    chk("flush_back_run", 32'(busy), 32'd0);

    // Reset in the middle of a clear walk
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    for (int i = 0; i < 300 && !(m_mode == M_WALK && m_idx == 50); i++) tick();
    chk("mid_walk_idx", 32'(clrIndex), 32'd50);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_walk_idx", 32'(clrIndex), 32'd0);
    chk("rst_walk_upd", 32'(updValid), 32'd0);
    repeat (CLR) tick();

    // Three branches, one mispredicted
    send(32'h500, 1'b1, 32'h600, 1'b1, 32'h600);
    send(32'h504, 1'b0, 32'h0, 1'b0, 32'h0);
    send(32'h508, 1'b1, 32'h700, 1'b1, 32'h780);
    resValid = 1'b0;
    tick();
`ifdef BPRED_STATS_EN
    chk("stat3_br", statBranches, 32'd3);
    chk("stat3_mp", statMispred, 32'd1);
`else
    chk("stat3_br", statBranches, 32'd0);
    chk("stat3_mp", statMispred, 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 399) != 0);
      flushReq      = ($urandom_range(0, 79) == 0);
      resValid      = ($urandom_range(0, 9) < 6);
      updReady      = ($urandom_range(0, 1) == 1);
      resPc         = $urandom() & 32'hFFFF_FFFC;
      resTaken      = ($urandom_range(0, 1) == 1);
      resTarget     = 32'h8000 + 32'($urandom_range(0, 3)) * 32'h40;
      resPredTaken  = ($urandom_range(0, 3) == 0) ? !resTaken : resTaken;
      resPredTarget = ($urandom_range(0, 1) == 0) ? resTarget : 32'h8000 + 32'($urandom_range(0, 3)) * 32'h40;
      tick();
    end
    rst = 1'b1; resValid = 1'b0; flushReq = 1'b0; updReady = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
